// File: rtl/onewire_rom_checker.sv
// Checks a latched 1-Wire ROM code: recomputes the Dallas CRC-8 bit-serially over bytes 0..6,
// compares it with byte 7, applies an optional family filter and counts CRC failures.
module onewire_rom_checker #(
    parameter logic [7:0] FAMILY_FILTER = 8'h00,
    parameter logic [7:0] CRC_POLY      = 8'h8C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rom_valid,
    input  logic [63:0] rom_code,
    input  logic        clr_err,
    output logic        rom_ready,
    output logic        busy,
    output logic        done,
    output logic        crc_ok,
    output logic        family_ok,
    output logic        rom_bad,
    output logic [7:0]  family_code,
    output logic [47:0] serial_num,
    output logic [7:0]  crc_calc,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_t;

    state_t      state;
    logic [63:0] rom_reg;
    logic [5:0]  bit_cnt;
    logic [7:0]  crc;
    logic [7:0]  crc_next;
    logic        fb;

    assign rom_ready = (state == StIdle);
    assign busy      = (state == StCalc);
    assign done      = (state == StDone);

    // One reflected CRC-8 step on the current serial bit (LSB of byte 0 first).
    always_comb begin
        fb       = crc[0] ^ rom_reg[bit_cnt];
        crc_next = {1'b0, crc[7:1]} ^ (fb ? CRC_POLY : 8'h00);
    end

    // Control FSM, CRC datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            rom_reg     <= 64'h0;
            bit_cnt     <= 6'd0;
            crc         <= 8'h00;
            crc_ok      <= 1'b0;
            family_ok   <= 1'b0;
            rom_bad     <= 1'b0;
            family_code <= 8'h00;
            serial_num  <= 48'h0;
            crc_calc    <= 8'h00;
            err_count   <= 8'h00;
        end else begin
            // Clear has priority over a failing check completing in the same cycle.
            if (clr_err) begin
                err_count <= 8'h00;
            end else if ((state == StDone) && !crc_ok && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            case (state)
                StIdle: begin
                    if (rom_valid) begin
                        rom_reg <= rom_code;
                        crc     <= 8'h00;
                        bit_cnt <= 6'd0;
                        state   <= StCalc;
                    end
                end
                StCalc: begin
                    crc <= crc_next;
                    if (bit_cnt == 6'd55) begin
                        state       <= StDone;
                        crc_calc    <= crc_next;
                        crc_ok      <= (crc_next == rom_reg[63:56]);
                        family_ok   <= (FAMILY_FILTER == 8'h00) ||
                                       (rom_reg[7:0] == FAMILY_FILTER);
                        rom_bad     <= (rom_reg == 64'h0) || (rom_reg == {64{1'b1}});
                        family_code <= rom_reg[7:0];
                        serial_num  <= rom_reg[55:8];
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onewire_rom_checker.sv
// Scoreboard bench for onewire_rom_checker: one unfiltered and one family-filtered instance.
module tb_onewire_rom_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rom_valid = 1'b0;
    logic [63:0] rom_code = 64'h0;
    logic        clr_err = 1'b0;

    logic        rom_ready, busy, done, crc_ok, family_ok, rom_bad;
    logic [7:0]  family_code, crc_calc, err_count;
    logic [47:0] serial_num;
    logic        rom_ready_f, busy_f, done_f, crc_ok_f, family_ok_f, rom_bad_f;
    logic [7:0]  family_code_f, crc_calc_f, err_count_f;
    logic [47:0] serial_num_f;

    localparam logic [63:0] T1_CODE = 64'hA200000001B81C02;
    localparam logic [63:0] T2_CODE = 64'hA300000001B81C02;

    typedef struct {
        logic [63:0] code;
        int          acc;
        logic [7:0]  crc;
        logic        ok;
        logic        bad;
    } exp_t;

    exp_t       sb[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         last_acc = -1;
    int         hold_accepts = 0;
    bit         hold = 1'b0;
    logic [7:0] model_err = 8'h00;
    bit         err_pending = 1'b0;
    bit         done_prev = 1'b0;
    logic [63:0] code28;

    onewire_rom_checker #(.FAMILY_FILTER(8'h00), .CRC_POLY(8'h8C)) dut (
        .clk(clk), .rst(rst), .rom_valid(rom_valid), .rom_code(rom_code), .clr_err(clr_err),
        .rom_ready(rom_ready), .busy(busy), .done(done), .crc_ok(crc_ok),
        .family_ok(family_ok), .rom_bad(rom_bad), .family_code(family_code),
        .serial_num(serial_num), .crc_calc(crc_calc), .err_count(err_count)
    );

    onewire_rom_checker #(.FAMILY_FILTER(8'h28), .CRC_POLY(8'h8C)) dut_f (
        .clk(clk), .rst(rst), .rom_valid(rom_valid), .rom_code(rom_code), .clr_err(clr_err),
        .rom_ready(rom_ready_f), .busy(busy_f), .done(done_f), .crc_ok(crc_ok_f),
        .family_ok(family_ok_f), .rom_bad(rom_bad_f), .family_code(family_code_f),
        .serial_num(serial_num_f), .crc_calc(crc_calc_f), .err_count(err_count_f)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Byte-wise reflected CRC-8 over bytes 0..6.
    function automatic logic [7:0] crc8(input logic [63:0] code);
        logic [7:0] c;
        c = 8'h00;
        for (int b = 0; b < 7; b++) begin
            c = c ^ code[8*b +: 8];
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
            end
        end
        return c;
    endfunction

    // Acceptance tracker: pushes the expected result at each handshake edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst && rom_valid && rom_ready) begin
                e.code = rom_code;
                e.acc  = cyc;
                e.crc  = crc8(rom_code);
                e.ok   = (e.crc == rom_code[63:56]);
                e.bad  = (rom_code == 64'h0) || (rom_code == {64{1'b1}});
                sb.push_back(e);
                if (hold) begin
                    hold_accepts++;
                    if (last_acc >= 0) check("accept_period", 64'(cyc - last_acc), 64'd58);
                    last_acc = cyc;
                end
            end
            if (!hold) last_acc = -1;
            cyc++;
        end
    end

    // Result monitor on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                model_err   = 8'h00;
                err_pending = 1'b0;
                done_prev   = 1'b0;
            end else begin
                if (err_pending) begin
                    check("err_count", 64'(err_count), 64'(model_err));
                    check("err_count_f", 64'(err_count_f), 64'(model_err));
                    err_pending = 1'b0;
                end
                check("done_match_f", 64'(done_f), 64'(done));
                if (done) begin
                    if (done_prev) check("done_overlap", 64'(done), 64'd0);
                    if (sb.size() == 0) begin
                        check("spurious_done", 64'(done), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("latency", 64'(cyc - e.acc), 64'd57);
                        check("crc_calc", 64'(crc_calc), 64'(e.crc));
                        check("crc_ok", 64'(crc_ok), 64'(e.ok));
                        check("family_ok", 64'(family_ok), 64'd1);
                        check("rom_bad", 64'(rom_bad), 64'(e.bad));
                        check("family_code", 64'(family_code), 64'(e.code[7:0]));
                        check("serial_num", 64'(serial_num), 64'(e.code[55:8]));
                        check("crc_ok_f", 64'(crc_ok_f), 64'(e.ok));
                        check("family_ok_f", 64'(family_ok_f), 64'(e.code[7:0] == 8'h28));
                    end
                end
                if (clr_err) begin
                    model_err = 8'h00;
                end else if (done && sb.size() == 0 && !(e.ok) && model_err != 8'hFF) begin
                    model_err = model_err + 8'd1;
                end
                if (done || clr_err) err_pending = 1'b1;
                done_prev = done;
            end
        end
    end

    task automatic send(input logic [63:0] code);
        bit acc;
        acc = 1'b0;
        @(posedge clk);
        #1;
        rom_valid = 1'b1;
        rom_code  = code;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(posedge clk);
            acc = rom_ready;
        end
        if (!acc) check("accept_timeout", 64'(rom_ready), 64'd1);
        #1;
        rom_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (sb.size() == 0 && rom_ready) break;
        end
        check("idle_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        code28 = {8'h00, 56'h00000ABCDEF128};
        code28[63:56] = crc8(code28);

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(rom_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_crc", 64'(crc_calc), 64'd0);
        rst = 1'b1;

        // T1 / T2: reference code and one corrupted CRC byte.
        send(T1_CODE);
        wait_idle();
        check("t1_crc", 64'(crc_calc), 64'hA2);
        check("t1_ok", 64'(crc_ok), 64'd1);
        check("t1_family", 64'(family_code), 64'h02);
        check("t1_serial", 64'(serial_num), 64'h00000001B81C);
        check("t1_family_ok_f", 64'(family_ok_f), 64'd0);
        send(T2_CODE);
        wait_idle();
        @(negedge clk);
        check("t2_crc", 64'(crc_calc), 64'hA2);
        check("t2_ok", 64'(crc_ok), 64'd0);
        check("t2_err", 64'(err_count), 64'd1);

        // T3 / T4: family filter and degenerate bus codes.
        send(code28);
        wait_idle();
        check("t3_family_ok_f", 64'(family_ok_f), 64'd1);
        check("t3_ok", 64'(crc_ok_f), 64'd1);
        send(64'h0);
        wait_idle();
        check("t4_zero_ok", 64'(crc_ok), 64'd1);
        check("t4_zero_bad", 64'(rom_bad), 64'd1);
        send({64{1'b1}});
        wait_idle();
        @(negedge clk);
        check("t4_ones_bad", 64'(rom_bad), 64'd1);
        check("t4_ones_ok", 64'(crc_ok), 64'd0);
        check("t4_ones_err", 64'(err_count), 64'd2);

        // T5: held valid, saturation, clear colliding with a failing DONE.
        @(posedge clk);
        #1;
        hold      = 1'b1;
        rom_code  = T1_CODE;
        rom_valid = 1'b1;
        repeat (237) @(posedge clk);
        #1;
        rom_valid = 1'b0;
        hold      = 1'b0;
        wait_idle();
        check("hold_accepts", 64'(hold_accepts), 64'd5);
        for (int n = 0; n < 260; n++) send(T2_CODE);
        wait_idle();
        @(negedge clk);
        check("sat_err", 64'(err_count), 64'hFF);
        send(T2_CODE);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        @(negedge clk);
        check("clr_on_done", 64'(err_count), 64'd0);

        // T6: reset during CALC, then a clean rerun.
        send(T2_CODE);
        wait_idle();
        send(T1_CODE);
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(rom_ready), 64'd1);
        check("abort_crc", 64'(crc_calc), 64'd0);
        check("abort_err", 64'(err_count), 64'd0);
        check("abort_serial", 64'(serial_num), 64'd0);
        repeat (60) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        send(T1_CODE);
        wait_idle();
        check("t6_crc", 64'(crc_calc), 64'hA2);
        check("t6_ok", 64'(crc_ok), 64'd1);
        @(negedge clk);
        check("t6_err", 64'(err_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
